// File: rtl/core8_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core8_timer_pkg
//  Purpose  : Shared constants for the core8 timer scheduler. Holds the timer
//             register map, the CONTROL register bit positions, and the
//             scheduler FSM state encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package core8_timer_pkg;

    // Timer slave-port register addresses
    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] c_ADDR_PERIODL = 3'd2;
    localparam logic [2:0] c_ADDR_PERIODH = 3'd3;

    // CONTROL register bit positions
    localparam int c_CTRL_ITO   = 0;
    localparam int c_CTRL_CONT  = 1;
    localparam int c_CTRL_START = 2;
    localparam int c_CTRL_STOP  = 3;

    // Data words written to CONTROL
    localparam logic [15:0] c_CTRL_WORD_STOP  = 16'(1 << c_CTRL_STOP);
    localparam logic [15:0] c_CTRL_WORD_START = 16'((1 << c_CTRL_START) | (1 << c_CTRL_ITO));

    // Scheduler FSM state encodings
    localparam int         c_ST_W     = 4;
    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_STOP  = 4'd1;
    localparam logic [3:0] c_ST_CLRS  = 4'd2;
    localparam logic [3:0] c_ST_WPL   = 4'd3;
    localparam logic [3:0] c_ST_WPH   = 4'd4;
    localparam logic [3:0] c_ST_START = 4'd5;
    localparam logic [3:0] c_ST_WAIT  = 4'd6;
    localparam logic [3:0] c_ST_ACK   = 4'd7;
    localparam logic [3:0] c_ST_DONE  = 4'd8;

endpackage
`default_nettype wire

// File: rtl/core8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : core8_rr_arbiter
//  Purpose  : N_REQ-way round-robin pick. Selects the first set request bit
//             strictly after the pointer (the last winner), wrapping around.
//  Ports    : req    - request vector
//             ptr    - index of the last winner
//             onehot - one-hot winner (all zero when no request)
//             idx    - winner index
//             valid  - at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module core8_rr_arbiter #(
    parameter int N_REQ = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest set bit after the
    // pointer is the last one assigned and therefore wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            w_sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (req[w_cand]) begin
                onehot         = '0;
                onehot[w_cand] = 1'b1;
                idx            = w_cand;
                valid          = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core8_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : core8_timer_sched
//  Purpose  : Shares one 32-bit interval timer among N_REQ requesters. A
//             round-robin winner is latched, the timer is programmed (stop,
//             clear status, period low/high, start one-shot), the scheduler
//             waits for tmr_irq, acknowledges it and pulses done to the winner.
//             Dropping req while waiting cancels the timer without a done.
//  Config   : TSCHED_WATCHDOG_EN - adds a watchdog that ends a wait after
//             ticks+WD_MARGIN cycles without irq and flags err with done.
//  Ports    : clk, reset_n (async, active-low)
//             req/req_ticks         - per-requester level request + tick count
//             done/err/busy/grant_id - completion pulse, watchdog error, status
//             tmr_*                 - timer slave write port, tmr_irq input
//  Revision : 1.0 - initial release
// ============================================================================
module core8_timer_sched
    import core8_timer_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int TICK_W    = 32,
    parameter int WD_MARGIN = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*TICK_W-1:0]   req_ticks,
    output logic [N_REQ-1:0]          done,
    output logic                      err,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic [2:0]                tmr_address,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [15:0]               tmr_writedata,
    input  logic                      tmr_irq
);

    localparam int c_ID_W = $clog2(N_REQ);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_next;
    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] r_grant_id;
    logic [N_REQ-1:0]  r_grant_oh;
    logic [31:0]       r_ticks;
    logic              r_cancel;
    logic              w_cancel_next;
    logic              r_wd_fire;
    logic              w_wd_fire_next;

    logic [N_REQ-1:0]  w_arb_onehot;
    logic [c_ID_W-1:0] w_arb_idx;
    logic              w_arb_valid;
    logic [TICK_W-1:0] w_sel_ticks;
    logic [31:0]       w_period;

    logic              w_cs_next;
    logic [2:0]        w_addr_next;
    logic [15:0]       w_data_next;

    logic              r_busy;
    logic [N_REQ-1:0]  r_done;
    logic [2:0]        r_tmr_address;
    logic              r_tmr_cs;
    logic [15:0]       r_tmr_writedata;

    core8_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (c_ID_W)
    ) u_arb (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_arb_onehot),
        .idx    (w_arb_idx),
        .valid  (w_arb_valid)
    );

    always_comb begin
        w_sel_ticks = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_onehot[i]) begin
                w_sel_ticks = req_ticks[i*TICK_W +: TICK_W];
            end
        end
    end

    // The timer fires ticks cycles after it starts running, so it is loaded
    // with ticks-1.
    assign w_period = r_ticks - 32'd1;

`ifdef TSCHED_WATCHDOG_EN
    logic [32:0] r_wd_cnt;
    logic        w_wd_expire;
    logic        r_err;

    // Expiry is taken on the cycle the counter would reach zero, so a wait
    // lasts exactly ticks+WD_MARGIN cycles.
    assign w_wd_expire = (r_wd_cnt <= 33'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_ST_START) begin
            r_wd_cnt <= {1'b0, r_ticks} + 33'(WD_MARGIN);
        end else if (r_state == c_ST_WAIT && r_wd_cnt != 33'd0) begin
            r_wd_cnt <= r_wd_cnt - 33'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_next == c_ST_DONE) && r_wd_fire;
        end
    end
    assign err = r_err;
`else
    logic w_wd_expire;
    assign w_wd_expire = 1'b0;
    assign err         = 1'b0;
`endif

    // Next-state logic. Cancel and watchdog both reuse the STOP/CLRS
    // sequence; the flags decide where CLRS goes afterwards.
    always_comb begin
        w_state_next   = r_state;
        w_cancel_next  = r_cancel;
        w_wd_fire_next = r_wd_fire;
        case (r_state)
            c_ST_IDLE: begin
                w_cancel_next  = 1'b0;
                w_wd_fire_next = 1'b0;
                if (w_arb_valid) begin
                    w_state_next = c_ST_STOP;
                end
            end
            c_ST_STOP: w_state_next = c_ST_CLRS;
            c_ST_CLRS: begin
                if (r_cancel) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_wd_fire || r_ticks == 32'd0) begin
                    w_state_next = c_ST_DONE;
                end else begin
                    w_state_next = c_ST_WPL;
                end
            end
            c_ST_WPL:   w_state_next = c_ST_WPH;
            c_ST_WPH:   w_state_next = c_ST_START;
            c_ST_START: w_state_next = c_ST_WAIT;
            c_ST_WAIT: begin
                // irq has priority over both cancel and watchdog expiry
                if (tmr_irq) begin
                    w_state_next = c_ST_ACK;
                end else if (!req[r_grant_id]) begin
                    w_state_next  = c_ST_STOP;
                    w_cancel_next = 1'b1;
                end else if (w_wd_expire) begin
                    w_state_next   = c_ST_STOP;
                    w_wd_fire_next = 1'b1;
                end
            end
            c_ST_ACK:  w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Bus word for the state being entered; registered so the write is
    // presented during that state.
    always_comb begin
        w_cs_next   = 1'b1;
        w_addr_next = 3'd0;
        w_data_next = 16'd0;
        case (w_state_next)
            c_ST_STOP:  begin w_addr_next = c_ADDR_CONTROL; w_data_next = c_CTRL_WORD_STOP;  end
            c_ST_CLRS:  begin w_addr_next = c_ADDR_STATUS;  w_data_next = 16'd0;             end
            c_ST_WPL:   begin w_addr_next = c_ADDR_PERIODL; w_data_next = w_period[15:0];    end
            c_ST_WPH:   begin w_addr_next = c_ADDR_PERIODH; w_data_next = w_period[31:16];   end
            c_ST_START: begin w_addr_next = c_ADDR_CONTROL; w_data_next = c_CTRL_WORD_START; end
            c_ST_ACK:   begin w_addr_next = c_ADDR_STATUS;  w_data_next = 16'd0;             end
            default:    w_cs_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_ST_IDLE;
            r_ptr           <= c_ID_W'(N_REQ-1);
            r_grant_id      <= '0;
            r_grant_oh      <= '0;
            r_ticks         <= '0;
            r_cancel        <= 1'b0;
            r_wd_fire       <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= '0;
            r_tmr_cs        <= 1'b0;
            r_tmr_address   <= 3'd0;
            r_tmr_writedata <= 16'd0;
        end else begin
            r_state         <= w_state_next;
            r_cancel        <= w_cancel_next;
            r_wd_fire       <= w_wd_fire_next;
            r_busy          <= (w_state_next != c_ST_IDLE);
            r_done          <= (w_state_next == c_ST_DONE) ? r_grant_oh : '0;
            r_tmr_cs        <= w_cs_next;
            r_tmr_address   <= w_addr_next;
            r_tmr_writedata <= w_data_next;
            if (r_state == c_ST_IDLE && w_arb_valid) begin
                r_ptr      <= w_arb_idx;
                r_grant_id <= w_arb_idx;
                r_grant_oh <= w_arb_onehot;
                r_ticks    <= 32'(w_sel_ticks);
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign grant_id       = r_grant_id;
    assign tmr_chipselect = r_tmr_cs;
    assign tmr_write_n    = ~r_tmr_cs;
    assign tmr_address    = r_tmr_address;
    assign tmr_writedata  = r_tmr_writedata;

endmodule
`default_nettype wire

// File: tb/tb_core8_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core8_timer_sched
//  Purpose  : Directed self-checking bench for core8_timer_sched (N_REQ=8,
//             TICK_W=32). Walks single requests, period boundaries, ticks=0,
//             full round-robin, cancel, irq/cancel collision and async reset.
//  Config   : TSCHED_WATCHDOG_EN - also exercises the watchdog expiry path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core8_timer_sched;

    localparam int c_N  = 8;
    localparam int c_TW = 32;

    logic              clk;
    logic              reset_n;
    logic [c_N-1:0]    req;
    logic [c_N*c_TW-1:0] req_ticks;
    logic [c_N-1:0]    done;
    logic              err;
    logic              busy;
    logic [2:0]        grant_id;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;

    int total;
    int bad;

    core8_timer_sched #(
        .N_REQ     (c_N),
        .TICK_W    (c_TW),
        .WD_MARGIN (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_ticks      (req_ticks),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {cs, write_n, address, writedata}
    function automatic logic [31:0] bus_word();
        return {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
    endfunction

    function automatic logic [31:0] wr_word(input logic [2:0] a, input logic [15:0] d);
        return {11'd0, 1'b1, 1'b0, a, d};
    endfunction

    localparam logic [31:0] c_BUS_IDLE = {11'd0, 1'b0, 1'b1, 3'd0, 16'd0};

    task automatic exp_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
        tick();
        chk(tag, bus_word(), wr_word(a, d));
    endtask

    task automatic set_ticks(input int i, input logic [31:0] v);
        req_ticks[i*c_TW +: c_TW] = v;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        req       = '0;
        req_ticks = '0;
        tmr_irq   = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_bus", bus_word(), c_BUS_IDLE);
        reset_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // ---- single req[0], ticks=100 ----
        set_ticks(0, 32'd100);
        req = 8'h01;
        exp_wr("t1_stop", 3'd1, 16'h0008);
        chk("t1_grant", 32'(grant_id), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        exp_wr("t1_clrs", 3'd0, 16'h0000);
        exp_wr("t1_pl", 3'd2, 16'd99);
        exp_wr("t1_ph", 3'd3, 16'd0);
        exp_wr("t1_start", 3'd1, 16'h0005);
        repeat (100) tick();
        chk("t1_wait_bus", bus_word(), c_BUS_IDLE);
        chk("t1_wait_done", 32'(done), 32'h0);
        tmr_irq = 1'b1;
        exp_wr("t1_ack", 3'd0, 16'h0000);
        chk("t1_ack_done", 32'(done), 32'h0);
        tmr_irq = 1'b0;
        tick();
        chk("t1_done", 32'(done), 32'h01);
        chk("t1_done_bus", bus_word(), c_BUS_IDLE);
        req = '0;
        tick();
        chk("t1_after_done", 32'(done), 32'h0);
        chk("t1_after_busy", 32'(busy), 32'h0);

        // ---- req[1], ticks=0x0001_0000 -> period 0x0000_FFFF ----
        set_ticks(1, 32'h0001_0000);
        req = 8'h02;
        exp_wr("t2_stop", 3'd1, 16'h0008);
        chk("t2_grant", 32'(grant_id), 32'h1);
        exp_wr("t2_clrs", 3'd0, 16'h0000);
        exp_wr("t2_pl", 3'd2, 16'hFFFF);
        exp_wr("t2_ph", 3'd3, 16'h0000);
        exp_wr("t2_start", 3'd1, 16'h0005);
        tick();
        tmr_irq = 1'b1;
        exp_wr("t2_ack", 3'd0, 16'h0000);
        tmr_irq = 1'b0;
        tick();
        chk("t2_done", 32'(done), 32'h02);
        req = '0;
        tick();

        // ---- req[2], ticks=0 -> no period programming ----
        set_ticks(2, 32'd0);
        req = 8'h04;
        exp_wr("t3_stop", 3'd1, 16'h0008);
        exp_wr("t3_clrs", 3'd0, 16'h0000);
        tick();
        chk("t3_done", 32'(done), 32'h04);
        chk("t3_bus", bus_word(), c_BUS_IDLE);
        req = '0;
        tick();
        chk("t3_busy", 32'(busy), 32'h0);

        // ---- all 8 held, ticks=5: grants 0..7 then 0 ----
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < c_N; i++) set_ticks(i, 32'd5);
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            exp_wr("rr_stop", 3'd1, 16'h0008);
            chk("rr_grant", 32'(grant_id), 32'(g % c_N));
            repeat (5) tick();
            tmr_irq = 1'b1;
            tick();
            tmr_irq = 1'b0;
            tick();
            chk("rr_done", 32'(done), 32'(1 << (g % c_N)));
            if (g == 8) req = '0;
            tick();
            chk("rr_done_clr", 32'(done), 32'h0);
        end

        // ---- req[3] dropped in WAIT -> cancel, no done ----
        set_ticks(3, 32'd50);
        req = 8'h08;
        exp_wr("t5_stop", 3'd1, 16'h0008);
        chk("t5_grant", 32'(grant_id), 32'h3);
        repeat (5) tick();
        tick();
        chk("t5_wait_bus", bus_word(), c_BUS_IDLE);
        req = '0;
        exp_wr("t5_cstop", 3'd1, 16'h0008);
        chk("t5_cstop_done", 32'(done), 32'h0);
        exp_wr("t5_cclrs", 3'd0, 16'h0000);
        tick();
        chk("t5_idle_done", 32'(done), 32'h0);
        chk("t5_idle_busy", 32'(busy), 32'h0);
        chk("t5_idle_bus", bus_word(), c_BUS_IDLE);

        // ---- irq and drop in the same WAIT cycle -> irq wins ----
        req = 8'h08;
        exp_wr("t6_stop", 3'd1, 16'h0008);
        repeat (5) tick();
        tmr_irq = 1'b1;
        req     = '0;
        exp_wr("t6_ack", 3'd0, 16'h0000);
        tmr_irq = 1'b0;
        tick();
        chk("t6_done", 32'(done), 32'h08);
        tick();
        chk("t6_busy", 32'(busy), 32'h0);

        // ---- reset during WAIT ----
        set_ticks(0, 32'd100);
        req = 8'h01;
        repeat (6) tick();
        chk("t7_wait_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t7_async_busy", 32'(busy), 32'h0);
        tick();
        chk("t7_rst_busy", 32'(busy), 32'h0);
        chk("t7_rst_done", 32'(done), 32'h0);
        chk("t7_rst_grant", 32'(grant_id), 32'h0);
        chk("t7_rst_bus", bus_word(), c_BUS_IDLE);
        reset_n = 1'b1;
        set_ticks(0, 32'd10);
        exp_wr("t7_rearb_stop", 3'd1, 16'h0008);
        chk("t7_rearb_grant", 32'(grant_id), 32'h0);
        exp_wr("t7_clrs", 3'd0, 16'h0000);
        exp_wr("t7_pl", 3'd2, 16'd9);
        exp_wr("t7_ph", 3'd3, 16'd0);
        exp_wr("t7_start", 3'd1, 16'h0005);
        tick();

`ifdef TSCHED_WATCHDOG_EN
        // ---- watchdog: ticks=10, margin 16, irq held low ----
        repeat (25) tick();
        chk("wd_still_wait", bus_word(), c_BUS_IDLE);
        exp_wr("wd_stop", 3'd1, 16'h0008);
        exp_wr("wd_clrs", 3'd0, 16'h0000);
        tick();
        chk("wd_done", 32'(done), 32'h01);
        chk("wd_err", 32'(err), 32'h1);
        req = '0;
        tick();
        chk("wd_err_clr", 32'(err), 32'h0);
`else
        // ---- no watchdog: WAIT persists, err stays low ----
        repeat (40) tick();
        chk("nowd_wait_bus", bus_word(), c_BUS_IDLE);
        chk("nowd_busy", 32'(busy), 32'h1);
        chk("nowd_err", 32'(err), 32'h0);
        req = '0;
        exp_wr("nowd_cstop", 3'd1, 16'h0008);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
